// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI frame scheduler.
// Frame = 2-bit command + 8-bit payload, shifted MSB first.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_TURN,
        S_RECV,
        S_GAP
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 8;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr and wraps;
// returns a one-hot grant plus the index of the winner.
module spi_rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [N-1:0] grant,
    output logic [1:0]   gid
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        gid   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N)
                idx = idx - N;
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && i == idx) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    gid      = 2'(i);
                end
            end
        end
    end

endmodule

// File: rtl/spi_master_sched.sv
// SPI master that serves NUM_REQ requesters round-robin,
// one 10-bit frame at a time, with optional 8-bit read-back.
import spi_ctrl_pkg::*;

module spi_master_sched #(
    parameter int NUM_REQ    = 2,
    parameter int TA_CYCLES  = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*10-1:0]   req_word,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    output logic [1:0]              rsp_id,
    output logic [7:0]              rsp_data,
    output logic                    busy,
    output logic                    SS_n,
    output logic                    MOSI,
    input  logic                    MISO
);

    localparam logic [CNT_W-1:0] SH_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] TA_LAST = CNT_W'(TA_CYCLES - 1);
    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GP_LAST = CNT_W'(GAP_CYCLES - 1);

    state_t              state;
    logic [1:0]          ptr;
    logic [1:0]          nxt;
    logic [1:0]          gid;
    logic [1:0]          id;
    logic [1:0]          cmd;
    logic [NUM_REQ-1:0]  grant;
    logic [FRAME_W-1:0]  word_sel;
    logic [FRAME_W-1:0]  sh;
    logic [DATA_W-1:0]   rx;
    logic [CNT_W-1:0]    cnt;
    logic                idle;

    spi_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .gid   (gid)
    );

    assign idle      = (state == S_IDLE);
    assign busy      = !idle;
    assign req_ready = (idle && !rst) ? grant : '0;
    assign nxt       = (gid == 2'(NUM_REQ - 1)) ? 2'd0 : gid + 2'd1;

    always_comb begin
        word_sel = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i])
                word_sel = req_word[10*i +: 10];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            ptr       <= '0;
            id        <= '0;
            cmd       <= '0;
            sh        <= '0;
            rx        <= '0;
            cnt       <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        state <= S_SHIFT;
                        SS_n  <= 1'b0;
                        MOSI  <= word_sel[FRAME_W-1];
                        sh    <= {word_sel[FRAME_W-2:0], 1'b0};
                        cmd   <= word_sel[9:8];
                        id    <= gid;
                        ptr   <= nxt;
                        cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    if (cnt == SH_LAST) begin
                        cnt  <= '0;
                        MOSI <= 1'b0;
                        if (cmd == CMD_RD_DATA) begin
                            state <= S_TURN;
                        end else begin
                            state <= S_GAP;
                            SS_n  <= 1'b1;
                        end
                    end else begin
                        cnt  <= cnt + 1'b1;
                        MOSI <= sh[FRAME_W-1];
                        sh   <= {sh[FRAME_W-2:0], 1'b0};
                    end
                end
                S_TURN: begin
                    if (cnt == TA_LAST) begin
                        cnt   <= '0;
                        state <= S_RECV;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RECV: begin
                    rx <= {rx[DATA_W-2:0], MISO};
                    if (cnt == RX_LAST) begin
                        cnt       <= '0;
                        state     <= S_GAP;
                        SS_n      <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_id    <= id;
                        rsp_data  <= {rx[DATA_W-2:0], MISO};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == GP_LAST) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
